// File: rtl/uart_tx_framer.sv
// UART transmitter: one frame per rising edge of tx_en, LSB first, one-entry holding buffer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 instead of 8N1).
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             tx_en_d_q;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic       rise;
    logic       bit_end;
    logic       load;
    logic       reload;
    logic [7:0] load_byte;

    assign rise = tx_en & ~tx_en_d_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        overrun_d  = 1'b0;
        load       = 1'b0;
        reload     = 1'b0;
        load_byte  = data_in;
        bit_end    = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        if (state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (rise) begin
                    load      = 1'b1;
                    load_byte = data_in;
                    state_d   = START;
                end else if (buf_full_q) begin
                    load       = 1'b1;
                    load_byte  = buf_q;
                    buf_full_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (buf_full_q) begin
                        load       = 1'b1;
                        load_byte  = buf_q;
                        buf_full_d = 1'b0;
                        reload     = 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A request landing on the buffer-reload cycle refills the slot just vacated.
        if (rise && (state_q != IDLE)) begin
            if (!buf_full_q || reload) begin
                buf_d      = data_in;
                buf_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (load) begin
            shift_d = load_byte;
`ifdef UART_TX_PARITY_EN
            par_d   = ^load_byte;
`endif
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE) | buf_full_d;
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    // The edge register follows tx_en through reset so a button held across reset sends nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_en_d_q  <= tx_en;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_en_d_q  <= tx_en;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule
